// File: rtl/udp_tx_arbiter_pkg.sv
// Shared types and constants for the multi-channel UDP TX arbiter.
// Optional oversize detection is enabled with the ZEUS_UDP_TX_OVERSIZE_EN macro.
package zeus_udp_tx_pkg;

  // Default geometry of the payload path (512-bit bus, 18-bit ids, 16-bit lengths).
  localparam int DATA_WIDTH_DFLT    = 512;
  localparam int BPB                = DATA_WIDTH_DFLT / 8;
  localparam int CONN_ID_WIDTH_DFLT = 18;
  localparam int LEN_WIDTH_DFLT     = 16;
  localparam int CHANNEL_WIDTH_DFLT = 2;

  // Arbiter FSM: IDLE picks the next packet, STREAM forwards it to tlast.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } tx_state_e;

  // Per-packet metadata record handed to the length/connection FIFOs.
  typedef struct packed {
    logic [LEN_WIDTH_DFLT-1:0]     length;
    logic [CONN_ID_WIDTH_DFLT-1:0] conn_id;
    logic [CHANNEL_WIDTH_DFLT-1:0] channel;
    logic                          oversize;
  } tx_meta_t;

endpackage

// File: rtl/udp_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches from pointer+1 upward (wrapping)
// and returns the first requesting channel as one-hot and as an index.
module rr_arbiter
  import zeus_udp_tx_pkg::*;
#(
  parameter int NUM_CHANNELS = 4
) (
  input  logic [NUM_CHANNELS-1:0]         req,
  input  logic [$clog2(NUM_CHANNELS)-1:0] pointer,
  output logic [NUM_CHANNELS-1:0]         grant,
  output logic [$clog2(NUM_CHANNELS)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_CHANNELS);

  int   cand;
  logic found;

  // Rotating priority search; the channel at the pointer is checked last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      cand = (int'(pointer) + k) % NUM_CHANNELS;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Multi-channel UDP TX front end: packet-level round-robin merge of user
// payload streams, connection lookup on the first beat, metadata on tlast.
// Define ZEUS_UDP_TX_OVERSIZE_EN to build the oversize flag and counter.
module udp_tx_arbiter
  import zeus_udp_tx_pkg::*;
#(
  parameter int NUM_CHANNELS      = 4,
  parameter int DATA_WIDTH        = 512,
  parameter int CONN_ID_WIDTH     = 18,
  parameter int LEN_WIDTH         = 16,
  parameter int MAX_PAYLOAD_BYTES = 1472
) (
  input  logic                                    tx_axis_aclk,
  input  logic                                    tx_axis_areset,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]      s_tx_axis_tdata,
  input  logic [NUM_CHANNELS*(DATA_WIDTH/8)-1:0]  s_tx_axis_tkeep,
  input  logic [NUM_CHANNELS-1:0]                 s_tx_axis_tvalid,
  input  logic [NUM_CHANNELS-1:0]                 s_tx_axis_tlast,
  output logic [NUM_CHANNELS-1:0]                 s_tx_axis_tready,
  input  logic [NUM_CHANNELS*CONN_ID_WIDTH-1:0]   s_tx_axis_connection_id,
  output logic [DATA_WIDTH-1:0]                   m_tx_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]                 m_tx_axis_tkeep,
  output logic                                    m_tx_axis_tvalid,
  output logic                                    m_tx_axis_tlast,
  input  logic                                    m_tx_axis_tready,
  output logic                                    m01_axis_rv_lookup_valid,
  output logic [CONN_ID_WIDTH-1:0]                m01_axis_rv_lookup_connectionId,
  output logic                                    m_meta_valid,
  input  logic                                    m_meta_ready,
  output logic [LEN_WIDTH-1:0]                    m_meta_length,
  output logic [CONN_ID_WIDTH-1:0]                m_meta_conn_id,
  output logic [$clog2(NUM_CHANNELS)-1:0]         m_meta_channel,
  output logic                                    m_meta_oversize,
  output logic [31:0]                             oversize_count
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CH_W  = $clog2(NUM_CHANNELS);

  tx_state_e                 state_r, state_next;
  logic [CH_W-1:0]           grant_r, ptr_r, arb_idx;
  logic [NUM_CHANNELS-1:0]   arb_onehot;
  logic                      arb_any;
  logic                      first_r;
  logic [LEN_WIDTH-1:0]      acc_r;
  logic [CONN_ID_WIDTH-1:0]  conn_r;

  logic [DATA_WIDTH-1:0]     sel_data;
  logic [BYTES-1:0]          sel_keep;
  logic                      sel_valid, sel_last;
  logic [CONN_ID_WIDTH-1:0]  sel_id;
  logic                      beat_ok, accept, load_meta;
  logic [LEN_WIDTH:0]        beat_bytes, len_sum;
  logic [LEN_WIDTH-1:0]      len_final;
  logic [CONN_ID_WIDTH-1:0]  id_final;

  rr_arbiter #(.NUM_CHANNELS(NUM_CHANNELS)) u_rr (
    .req       (s_tx_axis_tvalid),
    .pointer   (ptr_r),
    .grant     (arb_onehot),
    .grant_idx (arb_idx)
  );

  assign arb_any   = |arb_onehot;
  assign sel_data  = s_tx_axis_tdata[int'(grant_r)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_keep  = s_tx_axis_tkeep[int'(grant_r)*BYTES +: BYTES];
  assign sel_valid = s_tx_axis_tvalid[grant_r];
  assign sel_last  = s_tx_axis_tlast[grant_r];
  assign sel_id    = s_tx_axis_connection_id[int'(grant_r)*CONN_ID_WIDTH +: CONN_ID_WIDTH];

  // Byte accounting for the current beat with saturation of the running sum.
  always_comb begin
    beat_bytes = '0;
    len_sum    = '0;
    len_final  = '0;
    if (sel_last) begin
      beat_bytes = (LEN_WIDTH+1)'($countones(sel_keep));
    end else begin
      beat_bytes = (LEN_WIDTH+1)'(BYTES);
    end
    len_sum = {1'b0, acc_r} + beat_bytes;
    if (len_sum[LEN_WIDTH]) begin
      len_final = '1;
    end else begin
      len_final = len_sum[LEN_WIDTH-1:0];
    end
    id_final = first_r ? sel_id : conn_r;
  end

  // Stream mux, handshake and lookup pulse; everything idles at zero outside STREAM.
  always_comb begin
    m_tx_axis_tdata                 = '0;
    m_tx_axis_tkeep                 = '0;
    m_tx_axis_tvalid                = 1'b0;
    m_tx_axis_tlast                 = 1'b0;
    s_tx_axis_tready                = '0;
    m01_axis_rv_lookup_valid        = 1'b0;
    m01_axis_rv_lookup_connectionId = '0;
    beat_ok                         = 1'b1;
    accept                          = 1'b0;
    if (state_r == ST_STREAM) begin
      // A last beat waits while the previous packet's metadata is unread.
      beat_ok                   = !(sel_last && m_meta_valid && !m_meta_ready);
      m_tx_axis_tdata           = sel_data;
      m_tx_axis_tkeep           = sel_keep;
      m_tx_axis_tlast           = sel_last;
      m_tx_axis_tvalid          = sel_valid & beat_ok;
      s_tx_axis_tready[grant_r] = m_tx_axis_tready & beat_ok;
      accept                    = sel_valid & m_tx_axis_tready & beat_ok;
      m01_axis_rv_lookup_valid  = accept & first_r;
      if (accept && first_r) begin
        m01_axis_rv_lookup_connectionId = sel_id;
      end else begin
        m01_axis_rv_lookup_connectionId = '0;
      end
    end else begin
      beat_ok = 1'b1;
    end
  end

  assign load_meta = accept & sel_last;

  // Next-state logic: grant takes one cycle, tlast acceptance ends the packet.
  always_comb begin
    state_next = state_r;
    case (state_r)
      ST_IDLE:   state_next = arb_any ? ST_STREAM : ST_IDLE;
      ST_STREAM: state_next = load_meta ? ST_IDLE : ST_STREAM;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge tx_axis_aclk) begin
    if (tx_axis_areset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Grant, rotation pointer, first-beat flag, connection id and length accumulator.
  always_ff @(posedge tx_axis_aclk) begin
    if (tx_axis_areset) begin
      grant_r <= '0;
      ptr_r   <= CH_W'(NUM_CHANNELS - 1);
      first_r <= 1'b0;
      acc_r   <= '0;
      conn_r  <= '0;
    end else if (state_r == ST_IDLE) begin
      if (arb_any) begin
        grant_r <= arb_idx;
        ptr_r   <= arb_idx;
        first_r <= 1'b1;
      end
    end else if (accept) begin
      first_r <= 1'b0;
      if (first_r) begin
        conn_r <= sel_id;
      end
      acc_r <= sel_last ? '0 : len_final;
    end
  end

  // Metadata register: loads on tlast acceptance, holds until drained.
  always_ff @(posedge tx_axis_aclk) begin
    if (tx_axis_areset) begin
      m_meta_valid   <= 1'b0;
      m_meta_length  <= '0;
      m_meta_conn_id <= '0;
      m_meta_channel <= '0;
    end else if (load_meta) begin
      m_meta_valid   <= 1'b1;
      m_meta_length  <= len_final;
      m_meta_conn_id <= id_final;
      m_meta_channel <= grant_r;
    end else if (m_meta_ready) begin
      m_meta_valid <= 1'b0;
    end
  end

`ifdef ZEUS_UDP_TX_OVERSIZE_EN
  localparam logic [LEN_WIDTH:0] MAX_LEN = (LEN_WIDTH+1)'(MAX_PAYLOAD_BYTES);
  logic over_s;
  assign over_s = ({1'b0, len_final} > MAX_LEN);

  // Oversize flag travels with the metadata; the counter saturates.
  always_ff @(posedge tx_axis_aclk) begin
    if (tx_axis_areset) begin
      m_meta_oversize <= 1'b0;
      oversize_count  <= 32'd0;
    end else if (load_meta) begin
      m_meta_oversize <= over_s;
      if (over_s && (oversize_count != 32'hFFFF_FFFF)) begin
        oversize_count <= oversize_count + 32'd1;
      end
    end
  end
`else
  assign m_meta_oversize = 1'b0;
  assign oversize_count  = 32'd0;
`endif

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Self-checking bench for udp_tx_arbiter: packet-level source queues, a
// packet-level reference model checked every cycle, and directed scenarios
// with hand-computed expectations.
module tb_udp_tx_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 512;
  localparam int BB  = 64;
  localparam int CW  = 18;
  localparam int LW  = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH*DW-1:0]    s_tdata;
  logic [NCH*BB-1:0]    s_tkeep;
  logic [NCH-1:0]       s_tvalid, s_tlast, s_tready;
  logic [NCH*CW-1:0]    s_id;
  logic [DW-1:0]        m_tdata;
  logic [BB-1:0]        m_tkeep;
  logic                 m_tvalid, m_tlast, m_tready;
  logic                 lookup_valid;
  logic [CW-1:0]        lookup_id;
  logic                 m_meta_valid, m_meta_ready;
  logic [LW-1:0]        m_meta_length;
  logic [CW-1:0]        m_meta_conn_id;
  logic [1:0]           m_meta_channel;
  logic                 m_meta_oversize;
  logic [31:0]          oversize_count;

  udp_tx_arbiter dut (
    .tx_axis_aclk(clk), .tx_axis_areset(rst),
    .s_tx_axis_tdata(s_tdata), .s_tx_axis_tkeep(s_tkeep), .s_tx_axis_tvalid(s_tvalid),
    .s_tx_axis_tlast(s_tlast), .s_tx_axis_tready(s_tready), .s_tx_axis_connection_id(s_id),
    .m_tx_axis_tdata(m_tdata), .m_tx_axis_tkeep(m_tkeep), .m_tx_axis_tvalid(m_tvalid),
    .m_tx_axis_tlast(m_tlast), .m_tx_axis_tready(m_tready),
    .m01_axis_rv_lookup_valid(lookup_valid), .m01_axis_rv_lookup_connectionId(lookup_id),
    .m_meta_valid(m_meta_valid), .m_meta_ready(m_meta_ready), .m_meta_length(m_meta_length),
    .m_meta_conn_id(m_meta_conn_id), .m_meta_channel(m_meta_channel),
    .m_meta_oversize(m_meta_oversize), .oversize_count(oversize_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] nbeats;
    logic [63:0] lastkeep;
    logic [17:0] id;
    logic [15:0] serial;
  } pkt_t;

  typedef struct packed {
    logic [15:0] len;
    logic [17:0] id;
    logic [1:0]  ch;
    logic        ovr;
  } meta_t;

  pkt_t  srcq[NCH][$];
  int    bidx[NCH];
  logic [NCH-1:0] hold;
  logic  want_tready, toggle_tready;
  int    serial_ctr;

  meta_t expq[$];
  meta_t meta_log[$];
  int    meta_cyc_log[$];
  int    first_ch_log[$];
  int    first_cyc_log[$];
  int    last_pkt_beats;

  int    n_checks, n_fail, cyc;
  int    m_ptr, m_cur, m_beat;
  logic  m_in;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int c, input int s, input int b);
    logic [31:0] w;
    w = {8'(c), 16'(s), 8'(b)};
    return {16{w}};
  endfunction

  task automatic add_pkt(input int c, input int nb, input logic [63:0] lk, input logic [17:0] id);
    pkt_t p;
    p.nbeats   = 16'(nb);
    p.lastkeep = lk;
    p.id       = id;
    p.serial   = 16'(serial_ctr);
    serial_ctr++;
    srcq[c].push_back(p);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  function automatic int rr_pick(input int ptr);
    for (int k = 1; k <= NCH; k++) begin
      if (srcq[(ptr + k) % NCH].size() > 0) return (ptr + k) % NCH;
    end
    return -1;
  endfunction

  // Source driver: presents each channel's head packet, advances on accepted beats.
  initial begin
    logic [NCH-1:0] acc;
    s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0; s_id = '0;
    m_tready = 1'b1;
    forever begin
      @(negedge clk);
      acc = s_tvalid & s_tready & {NCH{!rst}};
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
        if (acc[c] && srcq[c].size() > 0) begin
          bidx[c]++;
          if (bidx[c] >= int'(srcq[c][0].nbeats)) begin
            void'(srcq[c].pop_front());
            bidx[c] = 0;
          end
        end
      end
      for (int c = 0; c < NCH; c++) begin
        if (srcq[c].size() > 0) begin
          s_tvalid[c] = !hold[c];
          s_tlast[c]  = (bidx[c] == int'(srcq[c][0].nbeats) - 1);
          s_tdata[c*DW +: DW] = beat_data(c, int'(srcq[c][0].serial), bidx[c]);
          s_tkeep[c*BB +: BB] = s_tlast[c] ? srcq[c][0].lastkeep : {BB{1'b1}};
          s_id[c*CW +: CW]    = srcq[c][0].id;
        end else begin
          s_tvalid[c] = 1'b0;
          s_tlast[c]  = 1'b0;
          s_tdata[c*DW +: DW] = '0;
          s_tkeep[c*BB +: BB] = '0;
          s_id[c*CW +: CW]    = '0;
        end
      end
      m_tready = toggle_tready ? ~m_tready : want_tready;
    end
  end

  // Reference model and per-cycle comparison of the DUT outputs.
  initial begin
    logic  acc_m, exp_last;
    pkt_t  p;
    meta_t e, got;
    int    ch, len;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        m_in = 1'b0; m_ptr = NCH - 1; m_cnt = 32'd0; m_beat = 0;
        expq.delete();
      end else begin
        chk("oversize_count", oversize_count, m_cnt);
        acc_m = m_tvalid & m_tready;
        chk("lookup_valid", lookup_valid, acc_m && !m_in);
        if (m_tlast && m_meta_valid && !m_meta_ready) chk("stalled_last_tvalid", m_tvalid, 1'b0);
        if (m_meta_valid) chk("meta_has_expectation", expq.size() > 0, 1'b1);
        if (m_meta_valid && m_meta_ready && expq.size() > 0) begin
          e = expq.pop_front();
          got = '{len: m_meta_length, id: m_meta_conn_id, ch: m_meta_channel, ovr: m_meta_oversize};
          chk("meta_length", m_meta_length, e.len);
          chk("meta_conn_id", m_meta_conn_id, e.id);
          chk("meta_channel", m_meta_channel, e.ch);
          chk("meta_oversize", m_meta_oversize, e.ovr);
          meta_log.push_back(got);
          meta_cyc_log.push_back(cyc);
        end
        if (acc_m) begin
          if (!m_in) begin
            ch = rr_pick(m_ptr);
            chk("arb_has_request", ch >= 0, 1'b1);
            if (ch >= 0) begin
              m_ptr = ch; m_cur = ch; m_beat = 0; m_in = 1'b1;
              first_ch_log.push_back(ch);
              first_cyc_log.push_back(cyc);
              chk("lookup_id", lookup_id, srcq[ch][0].id);
            end
          end
          if (m_in && srcq[m_cur].size() > 0) begin
            p = srcq[m_cur][0];
            exp_last = (m_beat == int'(p.nbeats) - 1);
            chk("beat_data", m_tdata, beat_data(m_cur, int'(p.serial), m_beat));
            chk("beat_keep", m_tkeep, exp_last ? p.lastkeep : {BB{1'b1}});
            chk("beat_last", m_tlast, exp_last);
            m_beat++;
            if (exp_last) begin
              len = (int'(p.nbeats) - 1) * BB + $countones(p.lastkeep);
              if (len > 65535) len = 65535;
              e.len = 16'(len);
              e.id  = p.id;
              e.ch  = 2'(m_cur);
`ifdef ZEUS_UDP_TX_OVERSIZE_EN
              e.ovr = (len > 1472);
`else
              e.ovr = 1'b0;
`endif
              expq.push_back(e);
              if (e.ovr && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
              last_pkt_beats = m_beat;
              m_in = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic wait_idle(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (srcq[0].size() == 0 && srcq[1].size() == 0 && srcq[2].size() == 0 &&
          srcq[3].size() == 0 && expq.size() == 0 && !m_meta_valid) break;
      tick(1);
    end
    chk({name, "_timeout"}, i < budget, 1'b1);
    tick(2);
  endtask

  task automatic clear_logs();
    meta_log.delete(); meta_cyc_log.delete(); first_ch_log.delete(); first_cyc_log.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ovr;
`ifdef ZEUS_UDP_TX_OVERSIZE_EN
    exp_ovr = 1;
`else
    exp_ovr = 0;
`endif
    rst = 1'b1; hold = '0; want_tready = 1'b1; toggle_tready = 1'b0; m_meta_ready = 1'b1;
    for (int c = 0; c < NCH; c++) bidx[c] = 0;
    tick(3);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_s_tready", s_tready, 4'h0);
    chk("rst_meta_valid", m_meta_valid, 1'b0);
    chk("rst_lookup", lookup_valid, 1'b0);
    chk("rst_meta_length", m_meta_length, 16'h0);
    chk("rst_oversize_count", oversize_count, 32'h0);
    rst = 1'b0;
    tick(1);

    // All channels busy with 1-beat packets; ch3's second packet has an empty last keep.
    clear_logs();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NCH; c++)
        add_pkt(c, 1, (r == 1 && c == 3) ? 64'h0 : {64{1'b1}}, 18'(16 * c + r + 1));
    wait_idle("rr", 100);
    chk("rr_count", first_ch_log.size(), 8);
    chk("rr_order0", first_ch_log[0], 0);
    chk("rr_order1", first_ch_log[1], 1);
    chk("rr_order2", first_ch_log[2], 2);
    chk("rr_order3", first_ch_log[3], 3);
    chk("rr_order4", first_ch_log[4], 0);
    for (int k = 0; k < 4; k++) chk("rr_gap", first_cyc_log[k+1] - first_cyc_log[k], 2);
    chk("rr_zero_keep_len", meta_log[7].len, 16'd0);

    // 3-beat packet on ch0 with a valid gap mid-packet while ch1 waits.
    clear_logs();
    add_pkt(0, 3, 64'h0000_0000_0000_FFFF, 18'h1234A);
    add_pkt(1, 1, {64{1'b1}}, 18'h00777);
    tick(3);
    hold[0] = 1'b1;
    tick(3);
    hold[0] = 1'b0;
    wait_idle("basic", 100);
    chk("basic_meta_count", meta_log.size(), 2);
    chk("basic_len", meta_log[0].len, 16'd144);
    chk("basic_ch", meta_log[0].ch, 2'd0);
    chk("basic_id", meta_log[0].id, 18'h1234A);
    chk("basic_second_ch", meta_log[1].ch, 2'd1);

    // Metadata back-pressure stalls the next packet's last beat.
    clear_logs();
    m_meta_ready = 1'b0;
    add_pkt(2, 1, 64'h0000_0000_0000_00FF, 18'h00A0A);
    add_pkt(3, 2, {64{1'b1}}, 18'h00B0B);
    tick(8);
    chk("stall_tvalid", m_tvalid, 1'b0);
    chk("stall_tlast", m_tlast, 1'b1);
    chk("stall_tready", s_tready, 4'h0);
    chk("stall_meta_valid", m_meta_valid, 1'b1);
    chk("stall_no_drain", meta_log.size(), 0);
    m_meta_ready = 1'b1;
    tick(4);
    chk("stall_drain_count", meta_log.size(), 2);
    chk("stall_a_len", meta_log[0].len, 16'd8);
    chk("stall_b_len", meta_log[1].len, 16'd128);
    chk("stall_b_next_cycle", meta_cyc_log[1] - meta_cyc_log[0], 1);
    wait_idle("stall", 50);

    // Downstream ready toggling every cycle during a 5-beat packet.
    clear_logs();
    toggle_tready = 1'b1;
    add_pkt(0, 5, {64{1'b1}}, 18'h0C0C0);
    wait_idle("toggle", 100);
    toggle_tready = 1'b0;
    tick(2);
    chk("toggle_len", meta_log[0].len, 16'd320);
    chk("toggle_beats", last_pkt_beats, 5);

    // Reset in the middle of a 4-beat packet on ch0.
    clear_logs();
    add_pkt(0, 4, {64{1'b1}}, 18'h0DDDD);
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("midrst_m_tvalid", m_tvalid, 1'b0);
    chk("midrst_s_tready", s_tready, 4'h0);
    chk("midrst_meta_valid", m_meta_valid, 1'b0);
    chk("midrst_lookup", lookup_valid, 1'b0);
    tick(1);
    for (int c = 0; c < NCH; c++) begin srcq[c].delete(); bidx[c] = 0; end
    add_pkt(1, 1, {64{1'b1}}, 18'h00111);
    add_pkt(0, 1, {64{1'b1}}, 18'h00222);
    tick(1);
    rst = 1'b0;
    wait_idle("midrst", 100);
    chk("midrst_meta_count", meta_log.size(), 2);
    chk("midrst_first_winner", first_ch_log[0], 0);
    chk("midrst_first_meta_id", meta_log[0].id, 18'h00222);

    // 24 full beats = 1536 bytes, above the oversize threshold.
    clear_logs();
    add_pkt(2, 24, {64{1'b1}}, 18'h02424);
    wait_idle("oversize", 200);
    chk("oversize_len", meta_log[0].len, 16'd1536);
    chk("oversize_flag", meta_log[0].ovr, exp_ovr);
    chk("oversize_cnt", oversize_count, 32'(exp_ovr));

    // 1025 full beats = 65600 bytes saturate the 16-bit length.
    clear_logs();
    add_pkt(1, 1025, {64{1'b1}}, 18'h3FFFF);
    wait_idle("saturate", 2000);
    chk("saturate_len", meta_log[0].len, 16'hFFFF);
    chk("saturate_cnt", oversize_count, 32'(2 * exp_ovr));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
